// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / loader) arbiter and three-state sequencer for the shared synchronous memory port.
// Round-robin on ties; LDR_Lock masks the CPU at arbitration time only.
module mem_port_arbiter #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CPU_Req,
    input  logic                 CPU_We,
    input  logic [AddrWidth-1:0] CPU_Addr,
    input  logic [DataWidth-1:0] CPU_DIn,
    output logic                 CPU_Ack,
    input  logic                 LDR_Req,
    input  logic                 LDR_We,
    input  logic [AddrWidth-1:0] LDR_Addr,
    input  logic [DataWidth-1:0] LDR_DIn,
    output logic                 LDR_Ack,
    input  logic                 LDR_Lock,
    output logic [DataWidth-1:0] RdData,
    output logic [AddrWidth-1:0] MEM_Addr,
    output logic [DataWidth-1:0] MEM_DIn,
    output logic                 MEM_Wr,
    output logic                 MEM_En,
    input  logic [DataWidth-1:0] MEM_DOut,
    output logic                 Busy,
    output logic                 Owner
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] din_q, din_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;

    logic cpu_elig;
    logic ldr_elig;
    logic grant_ldr;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rd_data_d = rd_data_q;

        cpu_elig  = CPU_Req & ~LDR_Lock;
        ldr_elig  = LDR_Req;
        // On a tie the port that did not win last time gets the grant.
        grant_ldr = (cpu_elig & ldr_elig) ? ~owner_q : ldr_elig;

        case (state_q)
            StIdle: begin
                if (cpu_elig | ldr_elig) begin
                    state_d = StAccess;
                    owner_d = grant_ldr;
                    we_d    = grant_ldr ? LDR_We   : CPU_We;
                    addr_d  = grant_ldr ? LDR_Addr : CPU_Addr;
                    din_d   = grant_ldr ? LDR_DIn  : CPU_DIn;
                end
            end
            StAccess: state_d = StDone;
            StDone: begin
                state_d = StIdle;
                if (!we_q) begin
                    rd_data_d = MEM_DOut;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        MEM_En   = (state_q != StAccess);
        MEM_Wr   = (state_q == StAccess) ? ~we_q : 1'b1;
        MEM_Addr = addr_q;
        MEM_DIn  = din_q;
        Busy     = (state_q != StIdle);
        Owner    = owner_q;
        CPU_Ack  = (state_q == StDone) & ~owner_q;
        LDR_Ack  = (state_q == StDone) & owner_q;
        // Memory data only arrives in the Done cycle, so forward it there to meet the Ack cycle.
        RdData   = ((state_q == StDone) && !we_q) ? MEM_DOut : rd_data_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: synchronous memory model plus a transaction-level reference
// (round-robin owner, reference memory array) driving directed and random traffic.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [7:0]  cpu_addr, ldr_addr;
    logic [15:0] cpu_din, ldr_din;
    logic        cpu_ack, ldr_ack;
    logic [15:0] rd_data;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_wr, mem_en;
    logic [15:0] mem_dout;
    logic        busy, owner;

    int tests = 0;
    int failed = 0;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        exp_owner;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_addr;
    logic [15:0] exp_din;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_en) begin
            if (!mem_wr) mem[mem_addr] <= mem_din;
            else         mem_dout <= mem[mem_addr];
        end
    end

    mem_port_arbiter #(.DataWidth(16), .AddrWidth(8)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .CPU_Req  (cpu_req),
        .CPU_We   (cpu_we),
        .CPU_Addr (cpu_addr),
        .CPU_DIn  (cpu_din),
        .CPU_Ack  (cpu_ack),
        .LDR_Req  (ldr_req),
        .LDR_We   (ldr_we),
        .LDR_Addr (ldr_addr),
        .LDR_DIn  (ldr_din),
        .LDR_Ack  (ldr_ack),
        .LDR_Lock (ldr_lock),
        .RdData   (rd_data),
        .MEM_Addr (mem_addr),
        .MEM_DIn  (mem_din),
        .MEM_Wr   (mem_wr),
        .MEM_En   (mem_en),
        .MEM_DOut (mem_dout),
        .Busy     (busy),
        .Owner    (owner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":en"}, 32'(mem_en), 32'd1);
        check({tag, ":wr"}, 32'(mem_wr), 32'd1);
        check({tag, ":acks"}, {30'd0, cpu_ack, ldr_ack}, 32'd0);
        check({tag, ":owner"}, 32'(owner), 32'(exp_owner));
        check({tag, ":rd"}, 32'(rd_data), 32'(exp_rdata));
        check({tag, ":addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, ":din"}, 32'(mem_din), 32'(exp_din));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_owner = 1'b1;
        exp_rdata = '0;
        exp_addr  = '0;
        exp_din   = '0;
    endtask

    // Called during an Idle cycle with requests driven; returns in the following Idle cycle.
    task automatic arb_cycle(input string tag);
        logic cpu_ok, ldr_ok, win;
        logic we;
        logic [7:0] a;
        logic [15:0] d;
        cpu_ok = cpu_req && !ldr_lock;
        ldr_ok = ldr_req;
        if (!cpu_ok && !ldr_ok) begin
            step();
            check_idle({tag, ":noreq"});
            return;
        end
        win = (cpu_ok && ldr_ok) ? !exp_owner : ldr_ok;
        we  = win ? ldr_we : cpu_we;
        a   = win ? ldr_addr : cpu_addr;
        d   = win ? ldr_din : cpu_din;
        exp_owner = win;
        exp_addr  = a;
        exp_din   = d;
        step();
        check({tag, ":acc_en"}, 32'(mem_en), 32'd0);
        check({tag, ":acc_wr"}, 32'(mem_wr), 32'(!we));
        check({tag, ":acc_addr"}, 32'(mem_addr), 32'(a));
        check({tag, ":acc_din"}, 32'(mem_din), 32'(d));
        check({tag, ":acc_busy"}, 32'(busy), 32'd1);
        check({tag, ":acc_owner"}, 32'(owner), 32'(win));
        check({tag, ":acc_acks"}, {30'd0, cpu_ack, ldr_ack}, 32'd0);
        step();
        if (we) ref_mem[a] = d;
        else    exp_rdata = ref_mem[a];
        check({tag, ":done_en"}, 32'(mem_en), 32'd1);
        check({tag, ":done_acks"}, {30'd0, cpu_ack, ldr_ack}, {30'd0, !win, win});
        check({tag, ":done_rd"}, 32'(rd_data), 32'(exp_rdata));
        if (win) ldr_req = 1'b0;
        else     cpu_req = 1'b0;
        step();
        check_idle({tag, ":post"});
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_din = '0;
        ldr_lock = 0;
        step();
        do_reset();
        check_idle("reset");

        // Preload every address through the loader so later reads have known contents.
        for (int i = 0; i < 256; i++) begin
            ldr_req = 1; ldr_we = 1; ldr_addr = 8'(i); ldr_din = 16'($urandom);
            arb_cycle("fill");
        end

        // Single CPU read of 0x10.
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h10; ldr_din = 16'hA5C3;
        arb_cycle("ld10");
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        arb_cycle("cpurd10");
        check("cpurd10_val", 32'(rd_data), 32'h0000A5C3);

        // Loader write then CPU read of 0x3F.
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h3F; ldr_din = 16'h1234;
        arb_cycle("ldwr3f");
        check("ldwr3f_owner", 32'(owner), 32'd1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h3F;
        arb_cycle("cpurd3f");
        check("cpurd3f_owner", 32'(owner), 32'd0);
        check("cpurd3f_val", 32'(rd_data), 32'h00001234);

        // Simultaneous requests after reset: CPU, LDR, CPU, LDR.
        do_reset();
        step();
        check_idle("rst2");
        cpu_we = 0; ldr_we = 0; cpu_addr = 8'h21; ldr_addr = 8'h42;
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1; ldr_req = 1;
            arb_cycle("tie");
            check("tie_order", 32'(owner), 32'(i % 2));
        end

        // Lock: only the loader is served; CPU wins once the lock drops and the loader is idle.
        ldr_lock = 1;
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; ldr_req = 1; ldr_we = 0; ldr_addr = 8'(i);
            arb_cycle("lock");
            check("lock_owner", 32'(owner), 32'd1);
        end
        ldr_lock = 0; ldr_req = 0;
        arb_cycle("unlock");
        check("unlock_owner", 32'(owner), 32'd0);

        // Reset during the access cycle of a CPU read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h77;
        step();
        check("rstacc_en", 32'(mem_en), 32'd0);
        rst = 1;
        step();
        rst = 0; cpu_req = 0;
        exp_owner = 1'b1; exp_rdata = '0; exp_addr = '0; exp_din = '0;
        check_idle("rstacc");
        step();
        check("rstacc_noack", 32'(cpu_ack), 32'd0);

        // Ten idle cycles leave every output unchanged.
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("idle");
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_din = 16'($urandom);
            end
            if (!ldr_req && $urandom_range(0, 1) == 1) begin
                ldr_req = 1; ldr_we = 1'($urandom); ldr_addr = 8'($urandom); ldr_din = 16'($urandom);
            end
            ldr_lock = ($urandom_range(0, 3) == 0);
            arb_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single synchronous program/data memory port. It shares the port between the CPU sequence controller (CPU port) and the program loader (LDR port). Each granted request runs a fixed three-state memory cycle that drives the existing MEM_En/MEM_Wr conventions, and returns one Ack pulse per access. It sits between the sequence control matrix / loader and the memory's address and data muxing.

## Interface
- DataWidth, 16, width of memory words and all data ports
- AddrWidth, 8, width of memory address and all address ports

- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- CPU_Req  in  1  CPU access request; held until CPU_Ack
- CPU_We  in  1  1 = write, 0 = read; stable while CPU_Req is high
- CPU_Addr  in  AddrWidth  CPU address; stable while CPU_Req is high
- CPU_DIn  in  DataWidth  CPU write data; stable while CPU_Req is high
- CPU_Ack  out  1  one-cycle pulse: CPU access complete, RdData valid for reads
- LDR_Req / LDR_We / LDR_Addr / LDR_DIn  in  1/1/AddrWidth/DataWidth  loader request, same rules as CPU
- LDR_Ack  out  1  one-cycle completion pulse for the loader
- LDR_Lock  in  1  while high, CPU_Req is ignored at arbitration
- RdData  out  DataWidth  registered read data, shared by both ports
- MEM_Addr  out  AddrWidth  memory address
- MEM_DIn  out  DataWidth  memory write data
- MEM_Wr  out  1  1 = read, 0 = write
- MEM_En  out  1  memory enable, active low
- MEM_DOut  in  DataWidth  memory read data, valid the cycle after the enabled cycle
- Busy  out  1  high in any state other than S_Idle
- Owner  out  1  port of the current or most recent grant (0 = CPU, 1 = LDR)

## Operation
- States: S_Idle, S_Access, S_Done. 2-bit state register.
- S_Idle: MEM_En=1. If any eligible request is present, choose a winner and latch into registers Owner, the op (We), the address, and the write data. Next state is S_Access. Otherwise stay in S_Idle.
- Eligible requests:
  - LDR_Req is always eligible.
  - CPU_Req is eligible only when LDR_Lock=0.
- Arbitration:
  - Single eligible request: grant it.
  - Both eligible: grant the port opposite Owner (round-robin).
- S_Access:
  - MEM_En=0, MEM_Addr and MEM_DIn from the latched values.
  - MEM_Wr = ~latched We.
  - Next state is S_Done, unconditionally.
- S_Done:
  - MEM_En=1.
  - For a read, RdData <= MEM_DOut. For a write, RdData holds its value.
  - The Ack of the Owner port is 1.
  - Next state is S_Idle.
- MEM_Addr, MEM_DIn and MEM_Wr hold their latched values outside S_Access. MEM_Wr is 1 when no write is in progress.
- A requester drops Req on the same edge at which it samples its Ack. A Req still high in the following S_Idle is treated as a new request.
- LDR_Lock changing mid-access does not abort the current access. It only affects the next arbitration.
- Only the port that was granted can receive an Ack. Both Acks are never high in the same cycle.

## Timing
- Reset values (on the edge where Reset=1):
  - state=S_Idle, MEM_En=1, MEM_Wr=1.
  - CPU_Ack=0, LDR_Ack=0, Busy=0.
  - Owner=1, so the CPU wins the first tie.
  - RdData=0, MEM_Addr=0, MEM_DIn=0.
- Latency: Req high in S_Idle cycle k gives MEM_En=0 in cycle k+1 and Ack=1 in cycle k+2. RdData is valid from cycle k+2 until the next read completes.
- Throughput: one access per 3 cycles. There is no back-to-back issue from S_Done.
- Busy is 1 in S_Access and S_Done. Ack and MEM_En are state decodes: registered state, no input-to-output combinational path.
- Reset mid-operation forces S_Idle on the next edge and suppresses any pending Ack. A write already enabled in S_Access may have completed in memory.
- Addresses are AddrWidth bits with no wrap logic. The arbiter does no address arithmetic.

## Test plan
- Single CPU read:
  - Stimulus: memory[0x10]=0xA5C3; CPU_Req=1, CPU_We=0, CPU_Addr=0x10.
  - Response: MEM_En=0 exactly one cycle (k+1) with MEM_Wr=1 and MEM_Addr=0x10. CPU_Ack pulse at k+2 with RdData=0xA5C3. LDR_Ack stays 0.
- Loader write then CPU read:
  - Stimulus: LDR writes 0x1234 to 0x3F, then the CPU reads 0x3F.
  - Response: MEM_Wr=0 during the LDR S_Access cycle. The CPU read returns 0x1234. Owner is 1 then 0.
- Simultaneous requests after reset:
  - Stimulus: both Req=1 continuously, re-asserted after each Ack.
  - Response: grants alternate CPU, LDR, CPU, LDR, with Acks 3 cycles apart.
- Lock:
  - Stimulus: LDR_Lock=1, both requesting.
  - Response: only LDR grants while the lock is held. The first arbitration after LDR_Lock falls grants the CPU if the LDR is idle. CPU_Ack is never asserted while locked.
- Reset in S_Access:
  - Stimulus: assert Reset during the S_Access cycle of a CPU read.
  - Response: next cycle state=S_Idle, MEM_En=1, Busy=0, no CPU_Ack, RdData=0, Owner=1.
- Idle behaviour:
  - Stimulus: no requests for 10 cycles.
  - Response: MEM_En stays 1, Busy stays 0, all outputs unchanged.
